mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 1: memory read latency in iCLK cycles, legal range 1..7.
REQ-002 SHALL have port iCLK, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port iRST_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port iReq, input, 1: CPU access request, sampled only when idle.
REQ-005 SHALL have port iWrite, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port iSize, input, 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-007 SHALL have port iUnsigned, input, 1: zero-extend load when 1, sign-extend when 0.
REQ-008 SHALL have port iAddr, input, 32: byte address.
REQ-009 SHALL have port iWData, input, 32: store data, right-justified.
REQ-010 SHALL have port oBusy, output, 1: high whenever not IDLE.
REQ-011 SHALL have port oDone, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port oRData, output, 32: extended load result.
REQ-013 SHALL have port oMisaligned, output, 1: one-cycle fault pulse.
REQ-014 SHALL have port oBadAddr, output, 32: address of the last faulting request.
REQ-015 SHALL have ports oReadEnable, oWriteEnable (output, 1 each), oByteEnable (output, 4), oAddress (output, 32), oWriteData (output, 32) and iReadData (input, 32): the memory bus.

Function
REQ-016 SHALL implement states IDLE, ACCESS, WAIT and DONE; all bus outputs SHALL be registered.
REQ-017 SHALL, in IDLE with iReq=1 and an aligned request, latch all request fields and enter ACCESS on that edge (cycle N).
REQ-018 SHALL treat half with iAddr[0]=1, word with iAddr[1:0]!=0, and any iSize=11 as misaligned: stay IDLE, pulse oMisaligned in N+1, load oBadAddr=iAddr, issue no bus strobe.
REQ-019 SHALL drive oAddress={addr[31:2],2'b00}.
REQ-020 SHALL drive oByteEnable as: byte -> 1<<addr[1:0]; half -> 0011 when addr[1]=0, 1100 otherwise; word -> 1111.
REQ-021 SHALL replicate store data as: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word unchanged.
REQ-022 SHALL, for a store, assert oWriteEnable exactly in cycle N+1, go to DONE, and pulse oDone in N+2.
REQ-023 SHALL, for a load, hold oReadEnable, oAddress and oByteEnable in cycles N+1..N+1+READ_LATENCY (ACCESS, then WAIT counting), sample iReadData at the edge ending N+1+READ_LATENCY, and pulse oDone with oRData valid in N+2+READ_LATENCY.
REQ-024 SHALL extract the load lane as iReadData>>(8*addr[1:0]), then take the low 8/16/32 bits and sign- or zero-extend per iUnsigned.
REQ-025 SHALL hold oRData from the last completed load until the next load completes; stores SHALL NOT alter it.
REQ-026 SHALL ignore iReq while oBusy=1, and SHALL accept a new request in the same cycle oDone is high only if state is IDLE; from DONE it SHALL return to IDLE.
REQ-027 SHALL keep the bus outputs at 0 outside ACCESS and WAIT, and SHALL never assert oReadEnable and oWriteEnable together.
REQ-028 SHALL pass iReadData in the high-impedance state (unmapped address) through as-is, with no error flag.

Reset
REQ-029 SHALL, on iRST_n low, asynchronously force state IDLE, the WAIT counter to 0, and every output to 0, including mid-access; this deasserts strobes without completing.
REQ-030 SHALL, after reset release, accept a request at the first rising edge.

Structure
REQ-031 SHALL place the iSize encodings and the state enumeration in shared package mem_access_pkg.
REQ-032 SHALL place byte-enable generation, store replication and load extraction in combinational sub-module mem_lane_align.

Verification
REQ-033 Store byte 0xA5 at 0x10010003 -> oByteEnable=1000, oWriteData=0xA5A5A5A5, oWriteEnable high in N+1 only, oDone in N+2.
REQ-034 Signed load half at 0x10010002 with iReadData=0x8001_1234 -> oRData=0xFFFF8001 in N+3 (READ_LATENCY=1); with iUnsigned=1 -> 0x00008001.
REQ-035 Load word at 0x10010006 -> oMisaligned pulse in N+1, oBadAddr=0x10010006, no strobe, oBusy stays 0.
REQ-036 READ_LATENCY=3, load word 0x00400000 -> oReadEnable held 4 cycles, oDone in N+5, and iReq during busy is ignored.
REQ-037 iRST_n low during WAIT -> strobes and oBusy drop to 0 immediately without an oDone pulse; the next request completes normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared access-size encodings, FSM states and alignment check
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_DONE
    } state_e;

    // Illegal size counts as misaligned so a single fault path covers both.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        return (size == SZ_ILL) || (size == SZ_HALF && lo[0]) || (size == SZ_WORD && lo != 2'b00);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-enable generation, store replication and load lane extraction
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_lane;

    // Lane selection and extension; the loaded lane is shifted down to bit 0 first.
    always_comb begin
        w_lane  = i_rdata >> {i_addr_lo, 3'b000};
        o_be    = (i_size == SZ_BYTE) ? 4'b0001 << i_addr_lo :
                  (i_size == SZ_HALF) ? (i_addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        o_wdata = (i_size == SZ_BYTE) ? {4{i_wdata[7:0]}} :
                  (i_size == SZ_HALF) ? {2{i_wdata[15:0]}} : i_wdata;
        o_rdata = (i_size == SZ_BYTE) ? {{24{w_lane[7] & ~i_unsigned}}, w_lane[7:0]} :
                  (i_size == SZ_HALF) ? {{16{w_lane[15] & ~i_unsigned}}, w_lane[15:0]} : w_lane;
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU load/store sequencer driving a registered memory bus
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iReq,
    input  logic        iWrite,
    input  logic [1:0]  iSize,
    input  logic        iUnsigned,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWData,
    output logic        oBusy,
    output logic        oDone,
    output logic [31:0] oRData,
    output logic        oMisaligned,
    output logic [31:0] oBadAddr,
    output logic        oReadEnable,
    output logic        oWriteEnable,
    output logic [3:0]  oByteEnable,
    output logic [31:0] oAddress,
    output logic [31:0] oWriteData,
    input  logic [31:0] iReadData
);

    state_e      r_state, w_next;
    logic [2:0]  r_cnt;
    logic        r_write, r_unsigned;
    logic [1:0]  r_size, r_lo;
    logic        w_accept, w_fault, w_wait_end, w_hold;
    logic [1:0]  w_size, w_lo;
    logic [3:0]  w_be;
    logic [31:0] w_wrep, w_rext;

    assign w_accept   = (r_state == ST_IDLE) && iReq && !is_misaligned(iSize, iAddr[1:0]);
    assign w_fault    = (r_state == ST_IDLE) && iReq && is_misaligned(iSize, iAddr[1:0]);
    assign w_wait_end = (r_state == ST_WAIT) && (r_cnt == 3'(READ_LATENCY - 1));
    assign w_hold     = oReadEnable && !w_wait_end;
    // In IDLE the aligner sees the incoming request; afterwards it sees the latched one.
    assign w_size     = (r_state == ST_IDLE) ? iSize : r_size;
    assign w_lo       = (r_state == ST_IDLE) ? iAddr[1:0] : r_lo;
    assign oBusy      = (r_state != ST_IDLE);

    mem_lane_align u_align (
        .i_size     (w_size),
        .i_addr_lo  (w_lo),
        .i_unsigned (r_unsigned),
        .i_wdata    (iWData),
        .i_rdata    (iReadData),
        .o_be       (w_be),
        .o_wdata    (w_wrep),
        .o_rdata    (w_rext)
    );

    // Next-state decode: stores skip WAIT, loads wait READ_LATENCY cycles.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   w_next = w_accept ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: w_next = r_write ? ST_DONE : ST_WAIT;
            ST_WAIT:   w_next = w_wait_end ? ST_DONE : ST_WAIT;
            default:   w_next = ST_IDLE;
        endcase
    end

    // State register and WAIT counter.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == ST_WAIT && !w_wait_end) ? r_cnt + 3'd1 : 3'd0;
        end
    end

    // Latch the request fields needed after acceptance.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= '0;
            r_lo       <= '0;
        end else if (w_accept) begin
            r_write    <= iWrite;
            r_unsigned <= iUnsigned;
            r_size     <= iSize;
            r_lo       <= iAddr[1:0];
        end
    end

    // Bus strobes: writes last one cycle, reads hold until the sampling edge.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oReadEnable  <= 1'b0;
            oWriteEnable <= 1'b0;
            oByteEnable  <= '0;
            oAddress     <= '0;
            oWriteData   <= '0;
        end else begin
            oReadEnable  <= w_accept ? !iWrite : w_hold;
            oWriteEnable <= w_accept && iWrite;
            oByteEnable  <= w_accept ? w_be : w_hold ? oByteEnable : 4'b0000;
            oAddress     <= w_accept ? {iAddr[31:2], 2'b00} : w_hold ? oAddress : 32'h0;
            oWriteData   <= (w_accept && iWrite) ? w_wrep : 32'h0;
        end
    end

    // Completion, fault pulse and held result registers.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oDone       <= 1'b0;
            oMisaligned <= 1'b0;
            oBadAddr    <= '0;
            oRData      <= '0;
        end else begin
            oDone       <= (w_next == ST_DONE);
            oMisaligned <= w_fault;
            oBadAddr    <= w_fault ? iAddr : oBadAddr;
            oRData      <= w_wait_end ? w_rext : oRData;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit at read latencies 1 and 3
module tb_mem_access_unit;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req = 1'b0, wr = 1'b0, uns = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0, wdata = '0, rdata = '0;

    logic        busy1, done1, mis1, re1, we1;
    logic [31:0] rd1, bad1, ad1, wd1;
    logic [3:0]  be1;
    logic        busy3, done3, mis3, re3, we3;
    logic [31:0] rd3, bad3, ad3, wd3;
    logic [3:0]  be3;

    int checks = 0, errors = 0;
    logic [31:0] q1[$], q3[$];
    logic [31:0] mdl_rd = '0;
    logic [31:0] e1, e3;

    logic        t1_re[13], t1_we[13], t1_done[13], t1_busy[13], t1_mis[13];
    logic [3:0]  t1_be[13];
    logic [31:0] t1_ad[13], t1_wd[13];
    logic        t3_re[13], t3_we[13], t3_done[13], t3_busy[13];
    logic        ab_re1, ab_re3, ab_busy1, ab_busy3;

    always #5 clk = ~clk;

    mem_access_unit #(.READ_LATENCY(1)) dut1 (
        .iCLK(clk), .iRST_n(rst_n), .iReq(req), .iWrite(wr), .iSize(size), .iUnsigned(uns),
        .iAddr(addr), .iWData(wdata), .oBusy(busy1), .oDone(done1), .oRData(rd1),
        .oMisaligned(mis1), .oBadAddr(bad1), .oReadEnable(re1), .oWriteEnable(we1),
        .oByteEnable(be1), .oAddress(ad1), .oWriteData(wd1), .iReadData(rdata)
    );

    mem_access_unit #(.READ_LATENCY(3)) dut3 (
        .iCLK(clk), .iRST_n(rst_n), .iReq(req), .iWrite(wr), .iSize(size), .iUnsigned(uns),
        .iAddr(addr), .iWData(wdata), .oBusy(busy3), .oDone(done3), .oRData(rd3),
        .oMisaligned(mis3), .oBadAddr(bad3), .oReadEnable(re3), .oWriteEnable(we3),
        .oByteEnable(be3), .oAddress(ad3), .oWriteData(wd3), .iReadData(rdata)
    );

    // Scoreboard: every completion pops the oRData expected for it.
    always @(negedge clk) begin
        if (done1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL sb1_unexpected_done rdata=%h", rd1);
            end else begin
                e1 = q1.pop_front();
                if (rd1 !== e1) begin
                    errors++;
                    $display("FAIL sb1_rdata got=%h exp=%h", rd1, e1);
                end
            end
        end
        if (done3) begin
            checks++;
            if (q3.size() == 0) begin
                errors++;
                $display("FAIL sb3_unexpected_done rdata=%h", rd3);
            end else begin
                e3 = q3.pop_front();
                if (rd3 !== e3) begin
                    errors++;
                    $display("FAIL sb3_rdata got=%h exp=%h", rd3, e3);
                end
            end
        end
        if ((re1 && we1) || (re3 && we3)) begin
            errors++;
            $display("FAIL strobe_overlap re1=%b we1=%b re3=%b we3=%b", re1, we1, re3, we3);
        end
    end

    function automatic logic [31:0] ext(input logic [1:0] s, input logic [1:0] lo, input logic u, input logic [31:0] d);
        logic [31:0] sh;
        sh = d >> (8 * lo);
        case (s)
            2'b00:   ext = u ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   ext = u ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: ext = sh;
        endcase
    endfunction

    task automatic expect_done(input logic [31:0] v);
        q1.push_back(v);
        q3.push_back(v);
    endtask

    task automatic issue(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a,
                         input logic [31:0] d, input int hold, input int abort_k);
        req = 1'b1; wr = w; size = s; uns = u; addr = a; wdata = d;
        @(posedge clk);
        #1;
        if (hold == 0) req = 1'b0;
        else begin
            wr = 1'b1;
            addr = 32'h0000_0100;
        end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            t1_re[k] = re1; t1_we[k] = we1; t1_done[k] = done1; t1_busy[k] = busy1; t1_mis[k] = mis1;
            t1_be[k] = be1; t1_ad[k] = ad1; t1_wd[k] = wd1;
            t3_re[k] = re3; t3_we[k] = we3; t3_done[k] = done3; t3_busy[k] = busy3;
            if (k >= hold) req = 1'b0;
            if (k == abort_k) begin
                rst_n = 1'b0;
                #1;
                ab_re1 = re1; ab_re3 = re3; ab_busy1 = busy1; ab_busy3 = busy3;
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({busy1, done1, rd1, mis1, bad1, re1, we1, be1, ad1, wd1} !== '0) begin
            errors++;
            $display("FAIL reset_dut1 busy=%b done=%b rd=%h mis=%b bad=%h re=%b we=%b be=%b ad=%h wd=%h exp all 0",
                     busy1, done1, rd1, mis1, bad1, re1, we1, be1, ad1, wd1);
        end
        checks++;
        if ({busy3, done3, rd3, mis3, bad3, re3, we3, be3, ad3, wd3} !== '0) begin
            errors++;
            $display("FAIL reset_dut3 busy=%b done=%b rd=%h re=%b we=%b exp all 0", busy3, done3, rd3, re3, we3);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_store;
        expect_done(mdl_rd);
        issue(1'b1, 2'b00, 1'b0, 32'h1001_0003, 32'h0000_00A5, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (t1_we[k] !== (k == 1) || t1_re[k] !== 1'b0) begin
                errors++;
                $display("FAIL store_we cycle=%0d we=%b re=%b exp we=%b re=0", k, t1_we[k], t1_re[k], k == 1);
            end
            checks++;
            if (t1_done[k] !== (k == 2) || t3_done[k] !== (k == 2) || t1_busy[k] !== (k <= 2)) begin
                errors++;
                $display("FAIL store_done cycle=%0d done1=%b done3=%b busy1=%b", k, t1_done[k], t3_done[k], t1_busy[k]);
            end
        end
        checks++;
        if (t1_be[1] !== 4'b1000 || t1_wd[1] !== 32'hA5A5_A5A5 || t1_ad[1] !== 32'h1001_0000) begin
            errors++;
            $display("FAIL store_bus be=%b wd=%h ad=%h exp be=1000 wd=a5a5a5a5 ad=10010000", t1_be[1], t1_wd[1], t1_ad[1]);
        end
        checks++;
        if (t1_be[2] !== 4'b0000 || t1_wd[2] !== 32'h0 || t1_ad[2] !== 32'h0) begin
            errors++;
            $display("FAIL store_bus_idle be=%b wd=%h ad=%h exp 0", t1_be[2], t1_wd[2], t1_ad[2]);
        end
    endtask

    task automatic test_load_half;
        rdata = 32'h8001_1234;
        for (int u = 0; u < 2; u++) begin
            mdl_rd = (u == 1) ? 32'h0000_8001 : 32'hFFFF_8001;
            expect_done(mdl_rd);
            issue(1'b0, 2'b01, u[0], 32'h1001_0002, 32'h0, 0, 0);
            for (int k = 1; k <= 6; k++) begin
                checks++;
                if (t1_re[k] !== (k <= 2) || t1_done[k] !== (k == 3) || t1_busy[k] !== (k <= 3)) begin
                    errors++;
                    $display("FAIL load_half_rl1 cycle=%0d re=%b done=%b busy=%b", k, t1_re[k], t1_done[k], t1_busy[k]);
                end
                checks++;
                if (t3_re[k] !== (k <= 4) || t3_done[k] !== (k == 5) || t3_busy[k] !== (k <= 5)) begin
                    errors++;
                    $display("FAIL load_half_rl3 cycle=%0d re=%b done=%b busy=%b", k, t3_re[k], t3_done[k], t3_busy[k]);
                end
            end
            checks++;
            if (t1_be[2] !== 4'b1100 || t1_ad[2] !== 32'h1001_0000 || t1_be[3] !== 4'b0000) begin
                errors++;
                $display("FAIL load_half_bus be2=%b ad2=%h be3=%b exp 1100 10010000 0000", t1_be[2], t1_ad[2], t1_be[3]);
            end
        end
    endtask

    task automatic test_misaligned;
        logic [1:0]  sz[3] = '{2'b10, 2'b01, 2'b11};
        logic [31:0] ad[3] = '{32'h1001_0006, 32'h1001_0001, 32'h1001_0000};
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, sz[i], 1'b0, ad[i], 32'h0, 0, 0);
            for (int k = 1; k <= 4; k++) begin
                checks++;
                if (t1_mis[k] !== (k == 1) || t1_busy[k] !== 1'b0 || t1_re[k] !== 1'b0 || t1_we[k] !== 1'b0 || t1_done[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL misaligned_%0d cycle=%0d mis=%b busy=%b re=%b we=%b done=%b", i, k, t1_mis[k], t1_busy[k], t1_re[k], t1_we[k], t1_done[k]);
                end
            end
            checks++;
            if (bad1 !== ad[i] || bad3 !== ad[i]) begin
                errors++;
                $display("FAIL badaddr_%0d got=%h/%h exp=%h", i, bad1, bad3, ad[i]);
            end
        end
    endtask

    task automatic test_latency3_busy_ignore;
        rdata = 32'hDEAD_BEEF;
        mdl_rd = 32'hDEAD_BEEF;
        expect_done(mdl_rd);
        issue(1'b0, 2'b10, 1'b0, 32'h0040_0000, 32'h0, 2, 0);
        for (int k = 1; k <= 12; k++) begin
            checks++;
            if (t3_re[k] !== (k <= 4) || t3_done[k] !== (k == 5) || t3_busy[k] !== (k <= 5) || t3_we[k] !== 1'b0 || t1_we[k] !== 1'b0) begin
                errors++;
                $display("FAIL rl3_busy cycle=%0d re=%b done=%b busy=%b we3=%b we1=%b", k, t3_re[k], t3_done[k], t3_busy[k], t3_we[k], t1_we[k]);
            end
        end
    endtask

    task automatic test_reset_mid_access;
        rdata = 32'h5555_AAAA;
        issue(1'b0, 2'b10, 1'b0, 32'h0040_0010, 32'h0, 0, 2);
        checks++;
        if (t3_re[2] !== 1'b1 || ab_re3 !== 1'b0 || ab_busy3 !== 1'b0 || ab_re1 !== 1'b0 || ab_busy1 !== 1'b0) begin
            errors++;
            $display("FAIL abort_strobes before_re3=%b re3=%b busy3=%b re1=%b busy1=%b exp 1 0 0 0 0", t3_re[2], ab_re3, ab_busy3, ab_re1, ab_busy1);
        end
        for (int k = 1; k <= 12; k++) begin
            checks++;
            if (t1_done[k] !== 1'b0 || t3_done[k] !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done cycle=%0d done1=%b done3=%b", k, t1_done[k], t3_done[k]);
            end
        end
        checks++;
        if (rd1 !== 32'h0 || rd3 !== 32'h0) begin
            errors++;
            $display("FAIL abort_rdata_cleared got=%h/%h exp=0", rd1, rd3);
        end
        rdata = 32'h1234_5678;
        mdl_rd = 32'h1234_5678;
        expect_done(mdl_rd);
        issue(1'b0, 2'b10, 1'b0, 32'h0040_0000, 32'h0, 0, 0);
        checks++;
        if (t1_done[3] !== 1'b1 || t3_done[5] !== 1'b1) begin
            errors++;
            $display("FAIL after_abort_done done1=%b done3=%b exp 1 1", t1_done[3], t3_done[5]);
        end
    endtask

    task automatic test_random_mix;
        logic [1:0]  s, lo;
        logic        w, u;
        logic [31:0] d, a;
        for (int i = 0; i < 10; i++) begin
            s  = 2'($urandom_range(0, 2));
            lo = (s == 2'b00) ? 2'($urandom_range(0, 3)) : (s == 2'b01) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            d  = $urandom;
            a  = ($urandom & 32'hFFFF_FFFC) | {30'h0, lo};
            rdata = $urandom;
            if (!w) mdl_rd = ext(s, lo, u, rdata);
            expect_done(mdl_rd);
            issue(w, s, u, a, d, 0, 0);
            checks++;
            if (t1_done[w ? 2 : 3] !== 1'b1 || t3_done[w ? 2 : 5] !== 1'b1) begin
                errors++;
                $display("FAIL random_%0d_timing w=%b done1=%b done3=%b", i, w, t1_done[w ? 2 : 3], t3_done[w ? 2 : 5]);
            end
            if (w) begin
                checks++;
                if (t1_wd[1] !== ((s == 2'b00) ? {4{d[7:0]}} : (s == 2'b01) ? {2{d[15:0]}} : d)) begin
                    errors++;
                    $display("FAIL random_%0d_wdata size=%b got=%h data=%h", i, s, t1_wd[1], d);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_store;
        test_load_half;
        test_misaligned;
        test_latency3_busy_ignore;
        test_reset_mid_access;
        test_random_mix;
        repeat (8) @(negedge clk);
        checks++;
        if (q1.size() != 0 || q3.size() != 0) begin
            errors++;
            $display("FAIL missing_done pending1=%0d pending3=%0d exp 0", q1.size(), q3.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
